// File: rtl/uart_ctl.sv
// Byte-I/O UART responder: 8N1 transmitter, oversampled receiver with a small RX FIFO,
// and the control FSM that answers uart_go send/receive requests with a uart_done pulse.
module uart_ctl #(
    parameter int CLK_PER_BIT = 868,
    parameter int RX_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_go,
    input  logic       rors,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       uart_done,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   FIFO_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} ctl_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    ctl_state_t    ctl_state_reg;
    logic          tx_go_reg;
    logic [7:0]    tx_data_reg;

    tx_state_t     tx_state_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [2:0]    tx_bit_reg;
    logic [7:0]    tx_shift_reg;

    logic          rx_s1_reg, rx_s2_reg, rx_prev_reg;
    rx_state_t     rx_state_reg;
    logic [CW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg;

    logic [7:0]    mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   fifo_cnt_reg;

    logic tx_end, rx_push, fifo_pop, push_ok;

    // SEND must leave on the very edge that ends the stop bit, so look at the TX state directly.
    assign tx_end   = (tx_state_reg == TX_STOP) && (tx_cnt_reg == BIT_LAST);
    assign rx_push  = (rx_state_reg == RX_STOP) && (rx_cnt_reg == BIT_LAST) && rx_s2_reg;
    assign fifo_pop = (ctl_state_reg == RECV) && (fifo_cnt_reg != '0);
    assign push_ok  = rx_push && ((fifo_cnt_reg != FIFO_FULL) || fifo_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctl_state_reg <= IDLE;
            tx_go_reg     <= 1'b0;
            tx_data_reg   <= 8'h00;
            rdata         <= 8'h00;
            uart_done     <= 1'b0;
        end else begin
            tx_go_reg <= 1'b0;
            uart_done <= 1'b0;
            case (ctl_state_reg)
                IDLE: begin
                    if (uart_go) begin
                        if (rors) begin
                            tx_data_reg   <= wdata;
                            tx_go_reg     <= 1'b1;
                            ctl_state_reg <= SEND;
                        end else begin
                            ctl_state_reg <= RECV;
                        end
                    end
                end
                SEND: begin
                    if (tx_end) begin
                        uart_done     <= 1'b1;
                        ctl_state_reg <= DONE;
                    end
                end
                RECV: begin
                    if (fifo_pop) begin
                        rdata         <= mem[rd_ptr_reg];
                        uart_done     <= 1'b1;
                        ctl_state_reg <= DONE;
                    end
                end
                default: ctl_state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h00;
            txd          <= 1'b1;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    tx_cnt_reg <= '0;
                    txd        <= 1'b1;
                    if (tx_go_reg) begin
                        tx_shift_reg <= tx_data_reg;
                        txd          <= 1'b0;
                        tx_state_reg <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_reg == BIT_LAST) begin
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= 3'd0;
                        txd          <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        tx_state_reg <= TX_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_reg == BIT_LAST) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            txd          <= 1'b1;
                            tx_state_reg <= TX_STOP;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                            txd          <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    if (tx_cnt_reg == BIT_LAST) begin
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= TX_IDLE;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1_reg    <= 1'b1;
            rx_s2_reg    <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h00;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1_reg   <= rxd;
            rx_s2_reg   <= rx_s1_reg;
            rx_prev_reg <= rx_s2_reg;
            case (rx_state_reg)
                RX_IDLE: begin
                    rx_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_s2_reg)
                        rx_state_reg <= RX_START;
                end
                RX_START: begin
                    // Half-bit re-check filters glitches and aligns later samples to mid-bit.
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= 3'd0;
                        rx_state_reg <= rx_s2_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7)
                            rx_state_reg <= RX_STOP;
                        else
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (!rx_s2_reg)
                            rx_frame_err <= 1'b1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= rx_shift_reg;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            rx_overrun   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (fifo_pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (push_ok && !fifo_pop)
                fifo_cnt_reg <= fifo_cnt_reg + FIFO_ONE;
            else if (!push_ok && fifo_pop)
                fifo_cnt_reg <= fifo_cnt_reg - FIFO_ONE;
            if (rx_push && !push_ok)
                rx_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/uart_ctl.md
Name: uart_ctl

Overview:
UART responder on the core side of the byte-I/O handshake. The control FSM raises uart_go with rors selecting send (1) or receive (0), then busy-waits on uart_done. This block serialises a send byte onto txd as 8N1. It also deserialises rxd into a small RX FIFO, so that bytes arriving before a receive request are kept, and returns the received byte on rdata.

Parameters:
CLK_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4
RX_DEPTH, 4, RX FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
uart_go  in  1  request strobe from control FSM; sampled only when ctl state is IDLE
rors  in  1  request type, sampled with uart_go: 1 = send byte, 0 = receive byte
wdata  in  8  byte to send, sampled with uart_go
rdata  out  8  last received byte; held until the next receive completes
uart_done  out  1  one-cycle completion pulse for the current request
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous
rx_overrun  out  1  sticky; set when a byte is dropped because the FIFO is full
rx_frame_err  out  1  sticky; set when a stop bit is sampled low

Behaviour:
- Reset (rstn=0 at posedge clk) puts all FSMs in IDLE and empties the FIFO. Output values during reset: rdata=0, uart_done=0, txd=1, rx_overrun=0, rx_frame_err=0. Reset mid-frame aborts the frame: txd returns high the cycle after reset, and a partial RX byte is discarded.
- Control FSM states: IDLE, SEND, RECV, DONE. All outputs are registered.
- IDLE: on uart_go=1 with rors=1, latch wdata, start the TX FSM and go to SEND. On uart_go=1 with rors=0, go to RECV.
- SEND: wait for the TX FSM to finish the stop bit, then go to DONE.
- RECV: if the FIFO is non-empty, pop the head into rdata and go to DONE. Otherwise stay in RECV with no timeout.
- DONE: uart_done=1 for exactly this one cycle, then go to IDLE.
- uart_go is ignored in SEND, RECV and DONE. A level-held uart_go is therefore re-accepted only after DONE.
- Receive latency with the FIFO non-empty: go sampled at edge k, rdata updated at edge k+1, uart_done high for the cycle after edge k+1.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP. Each bit lasts CLK_PER_BIT cycles, data is sent LSB first, and the frame is 10*CLK_PER_BIT cycles.
- txd drops low at edge k+1 after go is accepted at edge k.
- SEND exits at the end of the stop bit, so uart_done is high the cycle after txd has been high for one full CLK_PER_BIT.
- RX path: rxd passes through a 2-flop synchroniser (reset value 1). RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
- RX_IDLE to RX_START on a synchronised 1->0 edge.
- RX_START: after CLK_PER_BIT/2 cycles, re-sample. If high, treat as a glitch and return to RX_IDLE with no flag change.
- RX_DATA: sample 8 bits at CLK_PER_BIT intervals, mid-bit, LSB first.
- RX_STOP: sample once more. If high, push the byte into the FIFO. If low, discard the byte and set rx_frame_err. In either case return to RX_IDLE right after the stop sample, ready for back-to-back frames.
- FIFO: circular buffer with count width clog2(RX_DEPTH)+1.
  - Push when full: drop the byte and set rx_overrun; contents are unchanged.
  - Push and pop in the same cycle: both occur and count is unchanged. When full, a simultaneous push and pop counts as not-full for the push.
  - Pop when empty never occurs.
  - A push into an empty FIFO is visible to RECV the next cycle; there is no bypass.
- Sticky flags clear only on reset.

Test Plan:
- All scenarios use CLK_PER_BIT=4 and RX_DEPTH=4.
- Reset mid-frame: rstn=0 during the TX data bits of a send -> next cycle txd=1, uart_done=0, FSM in IDLE; a fresh send of 0x55 then completes normally.
- Send: uart_go=1, rors=1, wdata=0xA5 at edge k -> txd low from k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; uart_done high exactly one cycle, at k+41; uart_go held high meanwhile is not re-accepted early.
- Receive with data waiting: drive a frame of 0x3C on rxd before the request; then uart_go=1, rors=0 at edge k -> rdata=0x3C after k+1, uart_done pulse after k+1, FIFO empty.
- Receive blocking: issue the receive request with the FIFO empty and rxd idle for 100 cycles -> uart_done stays 0. Then send a frame of 0xC3 -> uart_done pulses within 3 cycles of the stop sample, rdata=0xC3.
- Overrun and ordering: send 5 frames 0x01..0x05 with no pops -> rx_overrun=1 after the 5th. Four receives then return 0x01, 0x02, 0x03, 0x04 in order.
- Framing error and glitch:
  - a frame with the stop bit low -> rx_frame_err=1, nothing pushed;
  - a 1-cycle low pulse on rxd -> no push, no flag change.
